// File: rtl/u_xmit_pkg.sv
// rtl/u_xmit_pkg.sv - shared UART constants: line levels, FSM encodings, frame defaults
// Defaults are shared with the receiver so both ends of the RS232 path agree.
package u_xmit_pkg;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int DEF_WORD_LEN = 8;
  localparam int DEF_BIT_CELL = 16;

  typedef enum logic [2:0] {
    t_IDLE   = 3'd0,
    t_START  = 3'd1,
    t_DATA   = 3'd2,
    t_PARITY = 3'd3,
    t_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/u_xmit.sv
// rtl/u_xmit.sv - UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits
// All outputs are registered; done and busy-low coincide in the final stop cycle.
module u_xmit
  import u_xmit_pkg::*;
#(
  parameter int WORD_LEN   = DEF_WORD_LEN,
  parameter int BIT_CELL   = DEF_BIT_CELL,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                xmitH,
  input  logic [WORD_LEN-1:0] xmit_dataH,
  output logic                uart_xmitH,
  output logic                xmit_busyH,
  output logic                xmit_doneH
);

  localparam int CW = $clog2(BIT_CELL);
  localparam int BW = $clog2(WORD_LEN + 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(BIT_CELL - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WORD_LEN - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WORD_LEN-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    // Busy is already low in the done cycle, so a request there starts a zero-gap frame.
    if (xmitH && !busy_q) begin
      state_d = t_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = xmit_dataH;
      par_d   = (^xmit_dataH) ^ (PARITY_ODD != 0);
    end else begin
      case (state_q)
        t_IDLE: ;
        t_START: begin
          if (cnt_q == CELL_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = t_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        t_DATA: begin
          if (cnt_q == CELL_LAST) begin
            cnt_d   = '0;
            shift_d = shift_q >> 1;
            if (bit_q == WORD_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? t_PARITY : t_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        t_PARITY: begin
          if (cnt_q == CELL_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = t_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // The bit counter is reused to count stop bits.
        t_STOP: begin
          if (cnt_q == CELL_LAST) begin
            cnt_d = '0;
            if (bit_q == STOP_LAST) begin
              bit_d   = '0;
              state_d = t_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = t_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_d)
      t_START:  line_d = LO;
      t_DATA:   line_d = shift_d[0];
      t_PARITY: line_d = par_d;
      default:  line_d = HI;
    endcase
    done_d = (state_d == t_STOP) && (cnt_d == CELL_LAST) && (bit_d == STOP_LAST);
    busy_d = (state_d != t_IDLE) && !done_d;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= t_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= LO;
      line_q  <= HI;
      busy_q  <= LO;
      done_q  <= LO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_xmitH = line_q;
  assign xmit_busyH = busy_q;
  assign xmit_doneH = done_q;

endmodule

// File: tb/tb_u_xmit.sv
// tb/tb_u_xmit.sv - scoreboard bench for u_xmit: 8N1 instance with loopback decoder, 8O2 instance
// Expected per-cycle line/busy/done is built from the frame format when a request is accepted.
module tb_u_xmit;

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IDLE_E = '{line: 1'b1, busy: 1'b0, done: 1'b0};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       xa, xb;
  logic [7:0] da, db;
  logic       line_a, busy_a, done_a;
  logic       line_b, busy_b, done_b;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] rxq[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         rx_got = 0;
  int         rx_exp = 0;

  always #5 clk = ~clk;

  u_xmit dut_a (
    .sys_clk(clk), .sys_rst(rst_a), .xmitH(xa), .xmit_dataH(da),
    .uart_xmitH(line_a), .xmit_busyH(busy_a), .xmit_doneH(done_a)
  );

  u_xmit #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .sys_clk(clk), .sys_rst(rst_b), .xmitH(xb), .xmit_dataH(db),
    .uart_xmitH(line_b), .xmit_busyH(busy_b), .xmit_doneH(done_b)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Frame as a bit list: start, data LSB first, optional parity, stop bits.
  function automatic int build(input logic [7:0] d, input int pe, input int odd, input int sb,
                               output logic [11:0] bits);
    int n = 0;
    bits = '0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pe != 0) begin bits[n] = 1'(($countones(d) + odd) % 2); n++; end
    for (int s = 0; s < sb; s++) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  task automatic push_frame(input int which, input logic [7:0] d);
    logic [11:0] b;
    int          n;
    exp_t        e;
    n = build(d, which, which, which + 1, b);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 16; c++) begin
        e.line = b[i];
        e.busy = 1'b1;
        e.done = 1'b0;
        if (i == n - 1 && c == 15) begin
          e.busy = 1'b0;
          e.done = 1'b1;
        end
        if (which != 0) qb.push_back(e);
        else qa.push_back(e);
      end
    end
    if (which == 0) begin
      rxq.push_back(d);
      rx_exp++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the request, waits for the accepting edge; caller is then in frame cycle 1.
  task automatic issue(input int which, input logic [7:0] d);
    if (which != 0) begin xb = 1'b1; db = d; end
    else begin xa = 1'b1; da = d; end
    @(posedge clk);
    #1;
    push_frame(which, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      e = (qa.size() != 0) ? qa.pop_front() : IDLE_E;
      chk("a_line", 32'(line_a), 32'(e.line));
      chk("a_busy", 32'(busy_a), 32'(e.busy));
      chk("a_done", 32'(done_a), 32'(e.done));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      e = (qb.size() != 0) ? qb.pop_front() : IDLE_E;
      chk("b_line", 32'(line_b), 32'(e.line));
      chk("b_busy", 32'(busy_b), 32'(e.busy));
      chk("b_done", 32'(done_b), 32'(e.done));
    end
  end

  // Loopback receiver on the 8N1 line: mid-cell sampling after a falling edge.
  initial begin : rx_model
    logic       prev;
    logic [7:0] w;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_a && prev && !line_a) begin
        repeat (7) @(negedge clk);
        chk("rx_start", 32'(line_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          w[i] = line_a;
        end
        repeat (16) @(negedge clk);
        chk("rx_stop", 32'(line_a), 32'd1);
        rx_got++;
        if (rxq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_word: got %0h, expected no frame", w);
        end else begin
          chk("rx_word", 32'(w), 32'(rxq.pop_front()));
        end
        prev = 1'b1;
      end else begin
        prev = line_a;
      end
    end
  end

  initial begin
    logic [7:0] sweep [4];
    logic [7:0] r;
    int         k;
    sweep[0] = 8'h00; sweep[1] = 8'hFF; sweep[2] = 8'h55; sweep[3] = 8'h80;
    rst_a = 1'b1; rst_b = 1'b1;
    xa = 1'b0; xb = 1'b0; da = '0; db = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_line", 32'(line_a), 32'd1);
    chk("rst_a_busy", 32'(busy_a), 32'd0);
    chk("rst_a_done", 32'(done_a), 32'd0);
    chk("rst_b_line", 32'(line_b), 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    wait_cycles(4);

    // 8N1 single frame
    issue(0, 8'hA5); xa = 1'b0; wait_cycles(159); wait_cycles(5);

    // request held high, data changed mid-frame: zero-gap second frame
    issue(0, 8'h3C); da = 8'hC3; wait_cycles(159);
    issue(0, 8'hC3); xa = 1'b0; wait_cycles(159); wait_cycles(5);

    // request during a frame is ignored
    issue(0, 8'h00); xa = 1'b0; wait_cycles(49);
    xa = 1'b1; da = 8'hFF; wait_cycles(1); xa = 1'b0;
    wait_cycles(109); wait_cycles(5);

    // sweep sent back to back
    for (int i = 0; i < 4; i++) begin
      issue(0, sweep[i]); xa = 1'b0; wait_cycles(159);
    end
    wait_cycles(3);

    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom);
      issue(0, r); xa = 1'b0; wait_cycles(159);
      wait_cycles($urandom_range(0, 3));
    end
    wait_cycles(10);

    // odd parity, two stop bits
    issue(1, 8'h07); xb = 1'b0; wait_cycles(191); wait_cycles(5);

    // asynchronous reset at cycle 70
    issue(1, 8'($urandom)); xb = 1'b0; wait_cycles(69);
    #2 rst_b = 1'b1;
    #1;
    chk("arst_line", 32'(line_b), 32'd1);
    chk("arst_busy", 32'(busy_b), 32'd0);
    chk("arst_done", 32'(done_b), 32'd0);
    qb.delete();
    @(posedge clk); #1;
    rst_b = 1'b0;
    wait_cycles(3);
    for (int i = 0; i < 3; i++) begin
      issue(1, 8'($urandom)); xb = 1'b0; wait_cycles(191);
      wait_cycles($urandom_range(0, 2));
    end

    k = 0;
    while (k < 2000 && (qa.size() != 0 || qb.size() != 0)) begin
      @(posedge clk);
      k++;
    end
    wait_cycles(40);
    chk("queue_drain", 32'(qa.size() + qb.size()), 32'd0);
    chk("rx_count", 32'(rx_got), 32'(rx_exp));
    chk("rx_pending", 32'(rxq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
